cmd_arbiter: RTL and testbench
==============================

CMD_ARBITER -- requirements
Module: cmd_arbiter

Interface
REQ-001 Parameters: none; all field widths are fixed to the DDR command FIFO format (1+27+6+128+16 = 178 bits).
REQ-002 clk  input  1  single clock, same domain as the command FIFO push side.
REQ-003 rstn  input  1  reset, asynchronous assert, active-low.
REQ-004 s0_valid / s1_valid  input  1  requester 0/1 has a command beat.
REQ-005 s0_ready / s1_ready  output  1  beat accepted from requester 0/1 this cycle (valid&&ready).
REQ-006 s0_cmd_type / s1_cmd_type  input  1  0=read, 1=write.
REQ-007 s0_addr / s1_addr  input  27  command address.
REQ-008 s0_burst_cnt / s1_burst_cnt  input  6  burst length in beats; 0 is treated as 1.
REQ-009 s0_wt_data / s1_wt_data  input  128  write data; s0_wt_mask / s1_wt_mask  input  16  byte mask.
REQ-010 io_push_valid  output  1  registered beat toward command FIFO.
REQ-011 io_push_ready  input  1  command FIFO not full.
REQ-012 io_push_cmd_type 1, io_push_addr 27, io_push_burst_cnt 6, io_push_wt_data 128, io_push_wt_mask 16  outputs  registered copy of the granted beat.
REQ-013 grant_id  output  1  requester index of the beat currently held in the output register.

Function
REQ-014 Output register loads when (!io_push_valid || io_push_ready); latency input-accept to io_push_valid = 1 cycle; full throughput of 1 beat/cycle when io_push_ready stays high.
REQ-015 At most one of s0_ready/s1_ready is high per cycle; a ready is never high when the output register cannot load.
REQ-016 Output fields and io_push_valid hold stable while io_push_valid && !io_push_ready.
REQ-017 FSM states: IDLE (arbitrate) and LOCK (write burst in progress).
REQ-018 IDLE, one requester valid: that requester is granted.
REQ-019 IDLE, both valid: round-robin; grant goes to the requester not granted last (last_grant register).
REQ-020 Read beat accepted in IDLE: single beat, stay IDLE, last_grant updated.
REQ-021 Write beat accepted in IDLE with effective burst length L>1: beat counter loads L-1, lock owner = granted port, go LOCK; L=1 stays IDLE.
REQ-022 LOCK: only the owner may receive ready; other requester stalls regardless of its valid; each accepted beat decrements counter; beat that brings counter to 0 returns FSM to IDLE and updates last_grant.
REQ-023 LOCK with owner valid low: no beat, counter and state hold (no timeout).
REQ-024 Beats inside LOCK are forwarded unchanged; arbiter does not check cmd_type/addr of continuation beats.
REQ-025 Burst counter 6 bits, never wraps: burst_cnt=63 yields 63 beats, burst_cnt=0 yields 1.

Reset
REQ-026 While rstn low: io_push_valid=0, all io_push_* data=0, grant_id=0, s0_ready=s1_ready=0, FSM=IDLE, counter=0, last_grant=1 (requester 0 wins first tie).
REQ-027 Reset mid-burst discards the held beat and the remaining burst; no beat is emitted on the first cycle after release.

Configuration
REQ-028 Macro CMD_ARB_FIXED_PRIO_EN: when defined, IDLE ties always grant requester 0 and last_grant is unused; when undefined, round-robin per REQ-019. Burst lock applies in both builds.

Verification
REQ-029 Both valid reads every cycle, io_push_ready=1, default build -> grants alternate 0,1,0,1; first beat from 0; io_push_valid 1 cycle after first accept.
REQ-030 s1 write burst_cnt=4 while s0 valid read -> 4 consecutive s1 beats on io_push, s0_ready=0 throughout, s0 granted on next beat.
REQ-031 io_push_ready=0 for 3 cycles with beat held -> io_push_* stable, s0_ready=s1_ready=0, no beat lost or duplicated after release.
REQ-032 Write burst_cnt=0 from s0 -> exactly 1 beat, FSM stays IDLE; burst_cnt=63 -> exactly 63 beats.
REQ-033 rstn low after 2 of 4 burst beats -> outputs 0 immediately (asynchronous), FSM IDLE after release, next tie granted to s0.
REQ-034 CMD_ARB_FIXED_PRIO_EN defined, both valid reads for 4 cycles -> all 4 beats from requester 0, s1_ready=0.

Source files
------------

// File: rtl/cmd_arbiter.sv
// Two-requester arbiter feeding the DDR command FIFO. A write burst locks the grant to its owner.
// Define CMD_ARB_FIXED_PRIO_EN to resolve IDLE ties to requester 0 instead of round-robin.
module cmd_arbiter (
    input  logic         clk,
    input  logic         rstn,
    input  logic         s0_valid,
    output logic         s0_ready,
    input  logic         s0_cmd_type,
    input  logic [26:0]  s0_addr,
    input  logic [5:0]   s0_burst_cnt,
    input  logic [127:0] s0_wt_data,
    input  logic [15:0]  s0_wt_mask,
    input  logic         s1_valid,
    output logic         s1_ready,
    input  logic         s1_cmd_type,
    input  logic [26:0]  s1_addr,
    input  logic [5:0]   s1_burst_cnt,
    input  logic [127:0] s1_wt_data,
    input  logic [15:0]  s1_wt_mask,
    output logic         io_push_valid,
    input  logic         io_push_ready,
    output logic         io_push_cmd_type,
    output logic [26:0]  io_push_addr,
    output logic [5:0]   io_push_burst_cnt,
    output logic [127:0] io_push_wt_data,
    output logic [15:0]  io_push_wt_mask,
    output logic         grant_id
);
    typedef enum logic {IDLE, LOCK} state_t;

    state_t       state, state_nxt;
    logic [5:0]   cnt, cnt_nxt;
    logic         owner, owner_nxt;
    logic         gnt, any_vld, accept, can_load;
    logic         sel_type;
    logic [26:0]  sel_addr;
    logic [5:0]   sel_bc;
    logic [127:0] sel_data;
    logic [15:0]  sel_mask;
`ifndef CMD_ARB_FIXED_PRIO_EN
    logic         last_grant, last_grant_nxt;
`endif

    assign can_load = !io_push_valid || io_push_ready;

    assign sel_type = gnt ? s1_cmd_type  : s0_cmd_type;
    assign sel_addr = gnt ? s1_addr      : s0_addr;
    assign sel_bc   = gnt ? s1_burst_cnt : s0_burst_cnt;
    assign sel_data = gnt ? s1_wt_data   : s0_wt_data;
    assign sel_mask = gnt ? s1_wt_mask   : s0_wt_mask;

    // Reset gates the handshake so no beat is taken while rstn is low.
    assign s0_ready = accept && !gnt;
    assign s1_ready = accept && gnt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        owner_nxt = owner;
        gnt       = 1'b0;
        any_vld   = 1'b0;
`ifndef CMD_ARB_FIXED_PRIO_EN
        last_grant_nxt = last_grant;
`endif
        if (state == LOCK) begin
            gnt     = owner;
            any_vld = owner ? s1_valid : s0_valid;
        end else begin
            any_vld = s0_valid || s1_valid;
            if (s0_valid && s1_valid) begin
`ifdef CMD_ARB_FIXED_PRIO_EN
                gnt = 1'b0;
`else
                gnt = ~last_grant;
`endif
            end else begin
                gnt = s1_valid;
            end
        end
        accept = any_vld && can_load && rstn;
        if (accept) begin
            if (state == IDLE) begin
                // burst_cnt 0 and 1 are both single-beat, so only >1 locks
                if (sel_type && (sel_bc > 6'd1)) begin
                    cnt_nxt   = sel_bc - 6'd1;
                    owner_nxt = gnt;
                    state_nxt = LOCK;
                end else begin
`ifndef CMD_ARB_FIXED_PRIO_EN
                    last_grant_nxt = gnt;
`endif
                end
            end else begin
                cnt_nxt = cnt - 6'd1;
                if (cnt == 6'd1) begin
                    state_nxt = IDLE;
`ifndef CMD_ARB_FIXED_PRIO_EN
                    last_grant_nxt = owner;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= 6'd0;
            owner <= 1'b0;
`ifndef CMD_ARB_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            owner <= owner_nxt;
`ifndef CMD_ARB_FIXED_PRIO_EN
            last_grant <= last_grant_nxt;
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            io_push_valid     <= 1'b0;
            io_push_cmd_type  <= 1'b0;
            io_push_addr      <= 27'd0;
            io_push_burst_cnt <= 6'd0;
            io_push_wt_data   <= 128'd0;
            io_push_wt_mask   <= 16'd0;
            grant_id          <= 1'b0;
        end else if (can_load) begin
            io_push_valid <= accept;
            if (accept) begin
                io_push_cmd_type  <= sel_type;
                io_push_addr      <= sel_addr;
                io_push_burst_cnt <= sel_bc;
                io_push_wt_data   <= sel_data;
                io_push_wt_mask   <= sel_mask;
                grant_id          <= gnt;
            end
        end
    end
endmodule

// File: tb/tb_cmd_arbiter.sv
// Scoreboard bench for cmd_arbiter: requester queues drive the ports, expected beats are
// queued in the order the arbitration rules dictate and checked as they leave io_push.
module tb_cmd_arbiter;
    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         s0_valid = 1'b0, s1_valid = 1'b0;
    logic         s0_ready, s1_ready;
    logic         s0_cmd_type = 1'b0, s1_cmd_type = 1'b0;
    logic [26:0]  s0_addr = '0, s1_addr = '0;
    logic [5:0]   s0_burst_cnt = '0, s1_burst_cnt = '0;
    logic [127:0] s0_wt_data = '0, s1_wt_data = '0;
    logic [15:0]  s0_wt_mask = '0, s1_wt_mask = '0;
    logic         io_push_valid;
    logic         io_push_ready = 1'b1;
    logic         io_push_cmd_type;
    logic [26:0]  io_push_addr;
    logic [5:0]   io_push_burst_cnt;
    logic [127:0] io_push_wt_data;
    logic [15:0]  io_push_wt_mask;
    logic         grant_id;

    typedef struct packed {
        logic         gid;
        logic         ct;
        logic [26:0]  addr;
        logic [5:0]   bc;
        logic [127:0] data;
        logic [15:0]  mask;
    } beat_t;

    beat_t q0[$], q1[$], sb[$];
    int total = 0, bad = 0;
    logic f0 = 1'b0, f1 = 1'b0;

    always #5 clk = ~clk;

    cmd_arbiter dut (
        .clk(clk), .rstn(rstn),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_cmd_type(s0_cmd_type), .s0_addr(s0_addr),
        .s0_burst_cnt(s0_burst_cnt), .s0_wt_data(s0_wt_data), .s0_wt_mask(s0_wt_mask),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_cmd_type(s1_cmd_type), .s1_addr(s1_addr),
        .s1_burst_cnt(s1_burst_cnt), .s1_wt_data(s1_wt_data), .s1_wt_mask(s1_wt_mask),
        .io_push_valid(io_push_valid), .io_push_ready(io_push_ready),
        .io_push_cmd_type(io_push_cmd_type), .io_push_addr(io_push_addr),
        .io_push_burst_cnt(io_push_burst_cnt), .io_push_wt_data(io_push_wt_data),
        .io_push_wt_mask(io_push_wt_mask), .grant_id(grant_id)
    );

    function automatic beat_t mk(input logic g, input logic ct, input logic [26:0] a, input logic [5:0] bc);
        beat_t b;
        b.gid  = g;
        b.ct   = ct;
        b.addr = a;
        b.bc   = bc;
        b.data = {4{5'h0, a}} ^ {32'hdead_beef, 96'h0};
        b.mask = a[15:0] ^ 16'ha5c3;
        return b;
    endfunction

    function automatic beat_t cur();
        return {grant_id, io_push_cmd_type, io_push_addr, io_push_burst_cnt, io_push_wt_data, io_push_wt_mask};
    endfunction

    // Requester models: present the queue head, pop it once the handshake completed.
    always begin
        @(negedge clk);
        f0 = s0_valid && s0_ready;
        f1 = s1_valid && s1_ready;
        @(posedge clk);
        #1;
        if (f0 && q0.size() > 0) void'(q0.pop_front());
        if (f1 && q1.size() > 0) void'(q1.pop_front());
        s0_valid = q0.size() > 0;
        if (q0.size() > 0) begin
            s0_cmd_type = q0[0].ct; s0_addr = q0[0].addr; s0_burst_cnt = q0[0].bc;
            s0_wt_data = q0[0].data; s0_wt_mask = q0[0].mask;
        end
        s1_valid = q1.size() > 0;
        if (q1.size() > 0) begin
            s1_cmd_type = q1[0].ct; s1_addr = q1[0].addr; s1_burst_cnt = q1[0].bc;
            s1_wt_data = q1[0].data; s1_wt_mask = q1[0].mask;
        end
    end

    task automatic monitor();
        beat_t exp_b, obs;
        forever begin
            @(negedge clk);
            if (rstn && io_push_valid && io_push_ready) begin
                obs = cur();
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_extra_beat got=%h want=none", obs);
                end else begin
                    exp_b = sb.pop_front();
                    if (obs !== exp_b) begin
                        bad++;
                        $display("FAIL sb_beat got=%h want=%h", obs, exp_b);
                    end
                end
            end
        end
    endtask

    task automatic wait_drain(input int lim, input string nm);
        int c = 0;
        while (c < lim && (sb.size() != 0 || q0.size() != 0 || q1.size() != 0 || io_push_valid)) begin
            @(posedge clk);
            #3;
            c++;
        end
        total++;
        if (sb.size() != 0 || q0.size() != 0 || q1.size() != 0 || io_push_valid) begin
            bad++;
            $display("FAIL %s_drain pending_beats=%0d want=0", nm, sb.size());
            q0.delete(); q1.delete(); sb.delete();
        end
    endtask

    task automatic test_reset();
        beat_t a, b;
        a = mk(0, 0, 27'h100, 6'd1);
        b = mk(1, 0, 27'h200, 6'd1);
        q0.push_back(a); q1.push_back(b);
        sb.push_back(a); sb.push_back(b);
        repeat (3) @(negedge clk);
        total++;
        if (s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
            bad++; $display("FAIL rst_ready got=%b%b want=00", s0_ready, s1_ready);
        end
        total++;
        if (io_push_valid !== 1'b0 || cur() !== '0) begin
            bad++; $display("FAIL rst_outputs got_valid=%b got=%h want=0", io_push_valid, cur());
        end
        @(posedge clk); #2 rstn = 1'b1;
        wait_drain(20, "rst_tie");
    endtask

    task automatic test_round_robin();
        @(posedge clk); #2;
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(0, 0, 27'h1000 + i, 6'd1));
            q1.push_back(mk(1, 0, 27'h2000 + i, 6'd1));
            sb.push_back(mk(0, 0, 27'h1000 + i, 6'd1));
            sb.push_back(mk(1, 0, 27'h2000 + i, 6'd1));
        end
        @(posedge clk);
        @(negedge clk);
        total++;
        if (s0_ready !== 1'b1 || s1_ready !== 1'b0 || io_push_valid !== 1'b0) begin
            bad++; $display("FAIL rr_first_accept got=%b%b v=%b want=10 v=0", s0_ready, s1_ready, io_push_valid);
        end
        @(negedge clk);
        total++;
        if (io_push_valid !== 1'b1 || grant_id !== 1'b0) begin
            bad++; $display("FAIL rr_latency got_v=%b gid=%b want v=1 gid=0", io_push_valid, grant_id);
        end
        wait_drain(30, "rr");
    endtask

    task automatic test_burst_lock();
        @(posedge clk); #2;
        for (int i = 0; i < 4; i++) begin
            q1.push_back(mk(1, 1, 27'h3000 + i, 6'd4));
            sb.push_back(mk(1, 1, 27'h3000 + i, 6'd4));
        end
        @(posedge clk); #2;
        q0.push_back(mk(0, 0, 27'h4000, 6'd1));
        sb.push_back(mk(0, 0, 27'h4000, 6'd1));
        repeat (4) begin
            @(negedge clk);
            total++;
            if (s0_ready !== 1'b0 || s1_ready !== 1'b1) begin
                bad++; $display("FAIL lock_ready got=%b%b want=01", s0_ready, s1_ready);
            end
        end
        @(negedge clk);
        total++;
        if (s0_ready !== 1'b1) begin
            bad++; $display("FAIL lock_release got=%b want=1", s0_ready);
        end
        wait_drain(20, "lock");
    endtask

    task automatic test_stall();
        beat_t r0;
        r0 = mk(0, 0, 27'h5000, 6'd1);
        @(posedge clk); #2;
        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk(0, 0, 27'h5000 + i, 6'd1));
            sb.push_back(mk(0, 0, 27'h5000 + i, 6'd1));
        end
        @(posedge clk);
        @(posedge clk); #2 io_push_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (io_push_valid !== 1'b1 || cur() !== r0) begin
                bad++; $display("FAIL stall_hold got_v=%b got=%h want=%h", io_push_valid, cur(), r0);
            end
            total++;
            if (s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
                bad++; $display("FAIL stall_ready got=%b%b want=00", s0_ready, s1_ready);
            end
        end
        @(posedge clk); #2 io_push_ready = 1'b1;
        wait_drain(20, "stall");
    endtask

    task automatic test_burst_edges();
        @(posedge clk); #2;
        q0.push_back(mk(0, 1, 27'h6000, 6'd0)); sb.push_back(mk(0, 1, 27'h6000, 6'd0));
        @(posedge clk); #2;
        q1.push_back(mk(1, 0, 27'h6100, 6'd1)); sb.push_back(mk(1, 0, 27'h6100, 6'd1));
        wait_drain(20, "bc0");
        @(posedge clk); #2;
        for (int i = 0; i < 63; i++) begin
            q0.push_back(mk(0, 1, 27'h7000 + i, 6'd63));
            sb.push_back(mk(0, 1, 27'h7000 + i, 6'd63));
        end
        @(posedge clk); #2;
        q1.push_back(mk(1, 0, 27'h7100, 6'd1)); sb.push_back(mk(1, 0, 27'h7100, 6'd1));
        wait_drain(120, "bc63");
    endtask

    task automatic test_reset_mid_burst();
        int c = 0;
        @(posedge clk); #2;
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(0, 1, 27'h8000 + i, 6'd4));
            sb.push_back(mk(0, 1, 27'h8000 + i, 6'd4));
        end
        @(posedge clk); #2;
        q1.push_back(mk(1, 0, 27'h8100, 6'd1)); sb.push_back(mk(1, 0, 27'h8100, 6'd1));
        while (c < 40 && sb.size() > 3) begin
            @(posedge clk); #3;
            c++;
        end
        total++;
        if (sb.size() > 3) begin
            bad++; $display("FAIL midrst_wait pending=%0d want<=3", sb.size());
        end
        rstn = 1'b0;
        #1;
        total++;
        if (io_push_valid !== 1'b0 || cur() !== '0 || s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
            bad++; $display("FAIL midrst_async got_v=%b rdy=%b%b got=%h want=0", io_push_valid, s0_ready, s1_ready, cur());
        end
        q0.delete(); q1.delete(); sb.delete();
        @(posedge clk);
        @(posedge clk); #2;
        q0.push_back(mk(0, 0, 27'h9000, 6'd1)); q1.push_back(mk(1, 0, 27'h9100, 6'd1));
        sb.push_back(mk(0, 0, 27'h9000, 6'd1)); sb.push_back(mk(1, 0, 27'h9100, 6'd1));
        @(posedge clk); #2 rstn = 1'b1;
        @(negedge clk);
        total++;
        if (io_push_valid !== 1'b0) begin
            bad++; $display("FAIL midrst_first_cycle got=%b want=0", io_push_valid);
        end
        wait_drain(20, "post_rst");
    endtask

    task automatic test_fixed_prio();
        @(posedge clk); #2;
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(0, 0, 27'ha000 + i, 6'd1));
            q1.push_back(mk(1, 0, 27'hb000 + i, 6'd1));
            sb.push_back(mk(0, 0, 27'ha000 + i, 6'd1));
        end
        for (int i = 0; i < 4; i++) sb.push_back(mk(1, 0, 27'hb000 + i, 6'd1));
        @(posedge clk);
        repeat (4) begin
            @(negedge clk);
            total++;
            if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin
                bad++; $display("FAIL fixed_ready got=%b%b want=10", s0_ready, s1_ready);
            end
        end
        wait_drain(30, "fixed");
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
`ifdef CMD_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_round_robin();
`endif
        test_burst_lock();
        test_stall();
        test_burst_edges();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
